// File: rtl/hex_dump_pkg.sv
// Shared types and ASCII constants for the register hex-dump engine and its
// character encoder.
package hex_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_LATCH = 3'd2,
        S_EMIT  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Length of the "xNN: " line prefix when labels are enabled.
    localparam int LABEL_LEN = 5;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_X     = 8'h78;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? ASCII_0 + {4'h0, nib} : ASCII_A + {4'h0, nib - 4'd10};
    endfunction

endpackage

// File: rtl/hex_dump_engine_encoder.sv
// Combinational character mux: selects the label character or the hex digit
// for one line position of a register dump.
module hex_char_encoder
    import hex_dump_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 5,
    parameter int POS_W      = 4,
    parameter int LABEL_EN   = 1
) (
    input  logic [POS_W-1:0]      i_pos,
    input  logic [IDX_W-1:0]      i_idx,
    input  logic [DATA_WIDTH-1:0] i_value,
    output logic [7:0]            o_ascii
);

    localparam int D = (DATA_WIDTH + 3) / 4;
    localparam int L = (LABEL_EN != 0) ? LABEL_LEN : 0;

    typedef logic [4*D-1:0] pad_t;

    pad_t       w_pad;
    logic [3:0] w_nib;
    int         w_num;

    always_comb begin
        w_pad   = pad_t'(i_value);
        w_num   = int'(i_idx) % 100;
        // Hex digits follow the label; digit 0 is the most significant nibble.
        w_nib   = 4'(w_pad >> (4 * (D - 1 - (int'(i_pos) - L))));
        o_ascii = nibble_to_ascii(w_nib);
        if (int'(i_pos) < L) begin
            case (int'(i_pos))
                0:       o_ascii = ASCII_X;
                1:       o_ascii = ASCII_0 + 8'(w_num / 10);
                2:       o_ascii = ASCII_0 + 8'(w_num % 10);
                3:       o_ascii = ASCII_COLON;
                default: o_ascii = ASCII_SPACE;
            endcase
        end
    end

endmodule

// File: rtl/hex_dump_engine.sv
// Dumps a run of registers as hex ASCII lines into the character buffer,
// one character per accepted write beat, with row wrap and start/busy/done.
module hex_dump_engine
    import hex_dump_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_REGS   = 32,
    parameter int          REG_AW     = 5,
    parameter int          COLS       = 80,
    parameter int          ROWS       = 60,
    parameter int          ADDR_W     = 13,
    parameter int          LABEL_EN   = 1,
    parameter logic [23:0] ATTR       = 24'hFFFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [REG_AW-1:0]         first_reg,
    input  logic [REG_AW:0]           reg_count,
    input  logic [$clog2(ROWS)-1:0]   base_row,
    output logic [REG_AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      char_we,
    output logic [ADDR_W-1:0]         char_addr,
    output logic [31:0]               char_data,
    input  logic                      char_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int D     = (DATA_WIDTH + 3) / 4;
    localparam int L     = (LABEL_EN != 0) ? LABEL_LEN : 0;
    localparam int LINE  = L + D;
    localparam int POS_W = $clog2(LINE + 1);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(LINE - 1);

    if (LINE > COLS) begin : g_bad_line
        $fatal(1, "hex_dump_engine: label plus digits do not fit in one row");
    end
    if (NUM_REGS > 100) begin : g_bad_regs
        $fatal(1, "hex_dump_engine: two-digit labels limit NUM_REGS to 100");
    end
    if (REG_AW < $clog2(NUM_REGS)) begin : g_bad_aw
        $fatal(1, "hex_dump_engine: REG_AW too narrow for NUM_REGS");
    end
    if (COLS * ROWS > (2 ** ADDR_W)) begin : g_bad_addr
        $fatal(1, "hex_dump_engine: screen does not fit in ADDR_W");
    end

    state_t                r_state;
    logic [REG_AW-1:0]     r_first;
    logic [REG_AW:0]       r_count;
    logic [REG_AW:0]       r_idx;
    logic [ROW_W-1:0]      r_row;
    logic [POS_W-1:0]      r_col;
    logic [DATA_WIDTH-1:0] r_value;

    logic [POS_W-1:0]      w_pos;
    logic [DATA_WIDTH-1:0] w_value;
    logic [7:0]            w_ascii;
    logic [ADDR_W-1:0]     w_char_addr;
    logic [REG_AW:0]       w_idx_next;

    // In LATCH the value register is not loaded yet, so the first character
    // is encoded straight from rd_data.
    always_comb begin
        w_pos       = (r_state == S_LATCH) ? '0 : r_col + 1'b1;
        w_value     = (r_state == S_LATCH) ? rd_data : r_value;
        w_char_addr = ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(w_pos);
        w_idx_next  = r_idx + 1'b1;
    end

    hex_char_encoder #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (REG_AW),
        .POS_W      (POS_W),
        .LABEL_EN   (LABEL_EN)
    ) u_encoder (
        .i_pos   (w_pos),
        .i_idx   (rd_addr),
        .i_value (w_value),
        .o_ascii (w_ascii)
    );

    // NOTE: state is only ever updated with non-blocking assignments so every
    // register samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_first   <= '0;
            r_count   <= '0;
            r_idx     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_value   <= '0;
            rd_addr   <= '0;
            char_we   <= 1'b0;
            char_addr <= '0;
            char_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_first <= first_reg;
                        r_count <= reg_count;
                        r_row   <= base_row;
                        r_idx   <= '0;
                        rd_addr <= first_reg;
                        busy    <= 1'b1;
                        r_state <= (reg_count == '0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: r_state <= S_LATCH;
                S_LATCH: begin
                    r_value   <= rd_data;
                    r_col     <= '0;
                    char_we   <= 1'b1;
                    char_addr <= w_char_addr;
                    char_data <= {w_ascii, ATTR};
                    r_state   <= S_EMIT;
                end
                S_EMIT: begin
                    if (char_ready) begin
                        if (r_col == LAST_POS) begin
                            char_we <= 1'b0;
                            r_state <= S_NEXT;
                        end else begin
                            r_col     <= w_pos;
                            char_addr <= w_char_addr;
                            char_data <= {w_ascii, ATTR};
                        end
                    end
                end
                S_NEXT: begin
                    r_idx <= w_idx_next;
                    r_row <= (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + 1'b1;
                    if (w_idx_next == r_count) begin
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        rd_addr <= r_first + w_idx_next[REG_AW-1:0];
                        r_state <= S_REQ;
                    end
                end
                S_DONE: begin
                    // A dump raises done on entry; the zero-count path arrives
                    // with done low and raises it here instead.
                    done    <= ~done;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_dump_engine.sv
// Directed bench for hex_dump_engine: default build plus a 12-bit, unlabelled
// build, each fed by a synchronous-read register file model.
module tb_hex_dump_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [4:0]  first_reg = '0;
    logic [5:0]  reg_count = '0;
    logic [5:0]  base_row = '0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        char_we;
    logic [12:0] char_addr;
    logic [31:0] char_data;
    logic        char_ready = 1'b1;
    logic        busy, done;

    logic        start2 = 1'b0;
    logic [4:0]  rd_addr2;
    logic [11:0] rd_data2;
    logic        char_we2;
    logic [12:0] char_addr2;
    logic [31:0] char_data2;
    logic        char_ready2 = 1'b1;
    logic        busy2, done2;

    hex_dump_engine dut (
        .clk(clk), .rst(rst), .start(start), .first_reg(first_reg),
        .reg_count(reg_count), .base_row(base_row), .rd_addr(rd_addr),
        .rd_data(rd_data), .char_we(char_we), .char_addr(char_addr),
        .char_data(char_data), .char_ready(char_ready), .busy(busy), .done(done)
    );

    hex_dump_engine #(.DATA_WIDTH(12), .LABEL_EN(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .first_reg(5'd5),
        .reg_count(6'd1), .base_row(6'd0), .rd_addr(rd_addr2),
        .rd_data(rd_data2), .char_we(char_we2), .char_addr(char_addr2),
        .char_data(char_data2), .char_ready(char_ready2), .busy(busy2), .done(done2)
    );

    logic [31:0] regs  [32];
    logic [11:0] regs2 [32];
    always @(posedge clk) rd_data  <= regs[rd_addr];
    always @(posedge clk) rd_data2 <= regs2[rd_addr2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    logic [12:0] q_addr[$];
    logic [31:0] q_data[$];
    int cyc = 0, start_cyc = 0, done_at, first_we, n_done, n_busy, held;
    int stall_left = 0;
    logic [12:0] stall_addr = '0;

    // One clock: drive ready, log accepted writes and handshake activity.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (char_we && char_addr == stall_addr && stall_left > 0) begin
            char_ready = 1'b0;
            stall_left--;
            if (char_data[31:24] == 8'h45) held++;
        end else begin
            char_ready = 1'b1;
        end
        if (char_we && char_ready) begin
            q_addr.push_back(char_addr);
            q_data.push_back(char_data);
        end
        if (done) begin
            n_done++;
            if (done_at < 0) done_at = cyc - start_cyc;
        end
        if (busy) n_busy++;
        if (char_we && first_we < 0) first_we = cyc - start_cyc;
    endtask

    task automatic launch(input logic [4:0] f, input logic [5:0] c, input logic [5:0] r);
        q_addr.delete();
        q_data.delete();
        done_at  = -1;
        first_we = -1;
        n_done   = 0;
        n_busy   = 0;
        held     = 0;
        first_reg = f;
        reg_count = c;
        base_row  = r;
        start     = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic run_dump(input string tag, input logic [4:0] f, input logic [5:0] c,
                            input logic [5:0] r);
        int i;
        launch(f, c, r);
        for (i = 0; i < 1500; i++) begin
            if (n_done > 0 && !busy && !done) break;
            step();
        end
        check({tag, "_timeout"}, 32'(i >= 1500), 32'd0);
        repeat (3) step();
    endtask

    task automatic check_line(input string tag, input string exp, input int base, input int qi);
        logic [7:0] ch;
        for (int k = 0; k < exp.len(); k++) begin
            ch = exp[k];
            if (qi + k < q_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, k), 32'(q_addr[qi + k]), 32'(base + k));
                check($sformatf("%s_data%0d", tag, k), q_data[qi + k], {ch, 24'hFFFFFF});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i;
        logic [11:0] w2_addr[$];
        logic [31:0] w2_data[$];
        int n_done2;

        foreach (regs[k]) regs[k] = '0;
        foreach (regs2[k]) regs2[k] = '0;
        regs[0]   = 32'hDEADBEEF;
        regs[30]  = 32'h0123ABCD;
        regs[31]  = 32'hFFFFFFFF;
        regs2[5]  = 12'hABC;

        repeat (3) @(negedge clk);
        check("rst_we", 32'(char_we), 32'd0);
        check("rst_addr", 32'(char_addr), 32'd0);
        check("rst_data", char_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdaddr", 32'(rd_addr), 32'd0);
        rst = 1'b1;
        step();

        // Single register, sink always ready.
        run_dump("basic", 5'd0, 6'd1, 6'd0);
        check("basic_writes", 32'(q_addr.size()), 32'd13);
        check_line("basic", "x00: DEADBEEF", 0, 0);
        check("basic_done_at", 32'(done_at), 32'd17);
        check("basic_done_cnt", 32'(n_done), 32'd1);
        check("basic_first_we", 32'(first_we), 32'd3);

        // Sink stalls three cycles on column 6.
        stall_addr = 13'd6;
        stall_left = 3;
        run_dump("stall", 5'd0, 6'd1, 6'd0);
        stall_left = 0;
        check("stall_writes", 32'(q_addr.size()), 32'd13);
        check("stall_held", 32'(held), 32'd3);
        check_line("stall", "x00: DEADBEEF", 0, 0);
        check("stall_done_at", 32'(done_at), 32'd20);
        check("stall_done_cnt", 32'(n_done), 32'd1);

        // Row wrap from the last row and register-index wrap past 31.
        run_dump("wrap", 5'd30, 6'd3, 6'd59);
        check("wrap_writes", 32'(q_addr.size()), 32'd39);
        check_line("wrap_r30", "x30: 0123ABCD", 4720, 0);
        check_line("wrap_r31", "x31: FFFFFFFF", 0, 13);
        check_line("wrap_r0", "x00: DEADBEEF", 80, 26);
        check("wrap_done_at", 32'(done_at), 32'd49);
        check("wrap_done_cnt", 32'(n_done), 32'd1);

        // Empty dump.
        run_dump("zero", 5'd3, 6'd0, 6'd0);
        check("zero_writes", 32'(q_addr.size()), 32'd0);
        check("zero_busy_cyc", 32'(n_busy), 32'd1);
        check("zero_done_at", 32'(done_at), 32'd2);
        check("zero_done_cnt", 32'(n_done), 32'd1);

        // Reset in the middle of a line, then a clean restart.
        launch(5'd0, 6'd1, 6'd0);
        for (i = 0; i < 100; i++) begin
            if (char_we && char_addr == 13'd4) break;
            step();
        end
        check("abort_reach_col4", 32'(i >= 100), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_we", 32'(char_we), 32'd0);
        check("abort_addr", 32'(char_addr), 32'd0);
        check("abort_data", char_data, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        n_done = 0;
        repeat (3) step();
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_we_held", 32'(char_we), 32'd0);
        rst = 1'b1;
        step();
        run_dump("restart", 5'd0, 6'd1, 6'd0);
        check("restart_writes", 32'(q_addr.size()), 32'd13);
        check_line("restart", "x00: DEADBEEF", 0, 0);
        check("restart_done_cnt", 32'(n_done), 32'd1);

        // 12-bit values without labels.
        n_done2 = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (char_we2) begin
                w2_addr.push_back(char_addr2[11:0]);
                w2_data.push_back(char_data2);
            end
            if (done2) n_done2++;
        end
        check("narrow_writes", 32'(w2_addr.size()), 32'd3);
        if (w2_addr.size() == 3) begin
            check("narrow_addr0", 32'(w2_addr[0]), 32'd0);
            check("narrow_addr1", 32'(w2_addr[1]), 32'd1);
            check("narrow_addr2", 32'(w2_addr[2]), 32'd2);
            check("narrow_data0", w2_data[0], 32'h41FFFFFF);
            check("narrow_data1", w2_data[1], 32'h42FFFFFF);
            check("narrow_data2", w2_data[2], 32'h43FFFFFF);
        end
        check("narrow_done_cnt", 32'(n_done2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
